pipe_skid_reg: RTL and testbench

Elastic pipeline stage register: the handshaked successor to the enable/clear pipeline flop used between datapath stages. It holds a WIDTH-bit payload with valid/ready flow control on both sides. A one-entry skid buffer keeps all ready outputs registered while sustaining one transfer per cycle. It sits between any two pipeline stages that need back-pressure and flush instead of a global stall/clear.

---
 rtl/pipe_skid_reg.sv | 115 +++++++++++
 tb/tb_pipe_skid_reg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready register with a one-entry skid buffer.
// in_ready, out_valid and occupancy are decoded from next-state and registered.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_occ;
  logic [1:0]       w_occ_nxt;
  logic             w_in_fire;
  logic             w_out_fire;

  // Handshakes are qualified only by registered ready/valid
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and datapath selection; flush overrides every handshake
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_skid_nxt  = in_data;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_BUSY;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    w_occ_nxt = 2'd0;
    unique case (w_state_nxt)
      ST_BUSY: w_occ_nxt = 2'd1;
      ST_FULL: w_occ_nxt = 2'd2;
      default: w_occ_nxt = 2'd0;
    endcase
  end

  // In reset in_ready is held low; it rises on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= RESET_VAL;
      r_skid      <= RESET_VAL;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_occ       <= w_occ_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed reset/stream/skid/flush scenarios on an
// 8-bit instance, then random valid/ready on 8- and 64-bit instances.
module tb_pipe_skid_reg;

  localparam int unsigned     W8          = 8;
  localparam int unsigned     W64         = 64;
  localparam logic [W8-1:0]   RV8         = 8'h5A;
  localparam logic [W64-1:0]  RV64        = 64'hDEAD_BEEF_0BAD_F00D;
  localparam int unsigned     RAND_CYCLES = 10000;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           iv8, ir8, ov8, or8;
  logic [W8-1:0]  id8, od8;
  logic [1:0]     oc8;
  logic           iv64, ir64, ov64, or64;
  logic [W64-1:0] id64, od64;
  logic [1:0]     oc64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(W8), .RESET_VAL(RV8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .occupancy(oc8)
  );

  pipe_skid_reg #(.WIDTH(W64), .RESET_VAL(RV64)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv64), .in_ready(ir64), .in_data(id64),
    .out_valid(ov64), .out_ready(or64), .out_data(od64), .occupancy(oc64)
  );

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; id8 = '0;
    iv64 = 1'b0; or64 = 1'b0; id64 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b0 || oc8 !== 2'd0 || od8 !== RV8) begin
      n_errors++;
      $display("FAIL reset_hold8: ov=%b ir=%b occ=%0d data=%h, expected 0 0 0 %h", ov8, ir8, oc8, od8, RV8);
    end
    n_checks++;
    if (ov64 !== 1'b0 || ir64 !== 1'b0 || oc64 !== 2'd0 || od64 !== RV64) begin
      n_errors++;
      $display("FAIL reset_hold64: ov=%b ir=%b occ=%0d data=%h, expected 0 0 0 %h", ov64, ir64, oc64, od64, RV64);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ir8 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release_no_edge: ir=%b, expected 0", ir8);
    end
    @(negedge clk);
    n_checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || ir64 !== 1'b1) begin
      n_errors++;
      $display("FAIL ready_after_edge: ir8=%b ov8=%b ir64=%b, expected 1 0 1", ir8, ov8, ir64);
    end
    iv8 = 1'b1; id8 = 8'h0A;
    @(negedge clk);
    id8 = 8'h0B;
    @(negedge clk);
    iv8 = 1'b0;
    n_checks++;
    if (oc8 !== 2'd2 || ir8 !== 1'b0 || od8 !== 8'h0A) begin
      n_errors++;
      $display("FAIL reset_prefill: occ=%0d ir=%b data=%h, expected 2 0 0a", oc8, ir8, od8);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b0 || oc8 !== 2'd0 || od8 !== RV8) begin
      n_errors++;
      $display("FAIL reset_async_full: ov=%b ir=%b occ=%0d data=%h, expected 0 0 0 %h", ov8, ir8, oc8, od8, RV8);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || oc8 !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_rerelease: ir=%b ov=%b occ=%0d, expected 1 0 0", ir8, ov8, oc8);
    end
  endtask

  task automatic test_streaming();
    logic [W8-1:0] q[$];
    logic [W8-1:0] exp_d;
    or8 = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_d = q.pop_front();
        n_checks++;
        if (ov8 !== 1'b1 || oc8 !== 2'd1 || ir8 !== 1'b1 || od8 !== exp_d) begin
          n_errors++;
          $display("FAIL stream_beat%0d: ov=%b occ=%0d ir=%b data=%h, expected 1 1 1 %h", i, ov8, oc8, ir8, od8, exp_d);
        end
      end
      if (i < 8) begin
        iv8 = 1'b1;
        id8 = 8'(i + 1);
        q.push_back(id8);
      end else begin
        iv8 = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0 || oc8 !== 2'd0) begin
      n_errors++;
      $display("FAIL stream_end: ov=%b occ=%0d, expected 0 0", ov8, oc8);
    end
  endtask

  task automatic test_skid_fill_drain();
    or8 = 1'b0; iv8 = 1'b1; id8 = 8'h0A;
    @(negedge clk);
    id8 = 8'h0B;
    n_checks++;
    if (ov8 !== 1'b1 || od8 !== 8'h0A || oc8 !== 2'd1 || ir8 !== 1'b1) begin
      n_errors++;
      $display("FAIL skid_first: ov=%b data=%h occ=%0d ir=%b, expected 1 0a 1 1", ov8, od8, oc8, ir8);
    end
    @(negedge clk);
    iv8 = 1'b0;
    n_checks++;
    if (ov8 !== 1'b1 || od8 !== 8'h0A || oc8 !== 2'd2 || ir8 !== 1'b0) begin
      n_errors++;
      $display("FAIL skid_full: ov=%b data=%h occ=%0d ir=%b, expected 1 0a 2 0", ov8, od8, oc8, ir8);
    end
    @(negedge clk);
    n_checks++;
    if (od8 !== 8'h0A || oc8 !== 2'd2 || ir8 !== 1'b0) begin
      n_errors++;
      $display("FAIL skid_hold: data=%h occ=%0d ir=%b, expected 0a 2 0", od8, oc8, ir8);
    end
    or8 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b1 || od8 !== 8'h0B || oc8 !== 2'd1 || ir8 !== 1'b1) begin
      n_errors++;
      $display("FAIL skid_drain_b: ov=%b data=%h occ=%0d ir=%b, expected 1 0b 1 1", ov8, od8, oc8, ir8);
    end
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0 || oc8 !== 2'd0 || ir8 !== 1'b1) begin
      n_errors++;
      $display("FAIL skid_empty: ov=%b occ=%0d ir=%b, expected 0 0 1", ov8, oc8, ir8);
    end
  endtask

  task automatic test_flush_collision();
    or8 = 1'b0; iv8 = 1'b1; id8 = 8'h0A;
    @(negedge clk);
    id8 = 8'h0B;
    @(negedge clk);
    n_checks++;
    if (oc8 !== 2'd2 || ir8 !== 1'b0 || od8 !== 8'h0A) begin
      n_errors++;
      $display("FAIL flush_prefill: occ=%0d ir=%b data=%h, expected 2 0 0a", oc8, ir8, od8);
    end
    flush = 1'b1; or8 = 1'b1; iv8 = 1'b1; id8 = 8'h0C;
    @(negedge clk);
    flush = 1'b0; iv8 = 1'b0;
    n_checks++;
    if (ov8 !== 1'b0 || oc8 !== 2'd0 || ir8 !== 1'b1 || od8 !== RV8) begin
      n_errors++;
      $display("FAIL flush_clear: ov=%b occ=%0d ir=%b data=%h, expected 0 0 1 %h", ov8, oc8, ir8, od8, RV8);
    end
    iv8 = 1'b1; id8 = 8'h33;
    @(negedge clk);
    iv8 = 1'b0;
    n_checks++;
    if (ov8 !== 1'b1 || od8 !== 8'h33 || oc8 !== 2'd1) begin
      n_errors++;
      $display("FAIL flush_first_accept: ov=%b data=%h occ=%0d, expected 1 33 1", ov8, od8, oc8);
    end
    @(negedge clk);
    n_checks++;
    if (ov8 !== 1'b0 || oc8 !== 2'd0) begin
      n_errors++;
      $display("FAIL flush_drain: ov=%b occ=%0d, expected 0 0", ov8, oc8);
    end
    or8 = 1'b0;
  endtask

  task automatic test_random();
    logic [W8-1:0]  q8[$];
    logic [W64-1:0] q64[$];
    logic [W8-1:0]  last8 = '0;
    logic [W64-1:0] last64 = '0;
    logic [W8-1:0]  drop8;
    logic [W64-1:0] drop64;
    logic           stall8 = 1'b0;
    logic           stall64 = 1'b0;
    int             sz8, sz64, bias;
    for (int c = 0; c < int'(RAND_CYCLES) + 8; c++) begin
      @(negedge clk);
      sz8  = q8.size();
      sz64 = q64.size();
      n_checks++;
      if (ov8 !== (sz8 != 0) || ir8 !== (sz8 != 2) || oc8 !== 2'(sz8)) begin
        n_errors++;
        $display("FAIL rand8_ctrl c=%0d: ov=%b ir=%b occ=%0d, expected occ=%0d", c, ov8, ir8, oc8, sz8);
      end
      if (sz8 != 0) begin
        n_checks++;
        if (od8 !== q8[0]) begin
          n_errors++;
          $display("FAIL rand8_data c=%0d: data=%h, expected %h", c, od8, q8[0]);
        end
      end
      if (stall8) begin
        n_checks++;
        if (od8 !== last8) begin
          n_errors++;
          $display("FAIL rand8_stall c=%0d: data=%h, expected held %h", c, od8, last8);
        end
      end
      n_checks++;
      if (ov64 !== (sz64 != 0) || ir64 !== (sz64 != 2) || oc64 !== 2'(sz64)) begin
        n_errors++;
        $display("FAIL rand64_ctrl c=%0d: ov=%b ir=%b occ=%0d, expected occ=%0d", c, ov64, ir64, oc64, sz64);
      end
      if (sz64 != 0) begin
        n_checks++;
        if (od64 !== q64[0]) begin
          n_errors++;
          $display("FAIL rand64_data c=%0d: data=%h, expected %h", c, od64, q64[0]);
        end
      end
      if (stall64) begin
        n_checks++;
        if (od64 !== last64) begin
          n_errors++;
          $display("FAIL rand64_stall c=%0d: data=%h, expected held %h", c, od64, last64);
        end
      end
      if (c < int'(RAND_CYCLES)) begin
        bias  = (c / 1000) % 4;
        flush = ($urandom_range(0, 299) == 0);
        iv8   = ($urandom_range(0, 3) != 0);
        or8   = ($urandom_range(0, 3) >= bias);
        id8   = 8'($urandom);
        iv64  = ($urandom_range(0, 3) >= (3 - bias));
        or64  = ($urandom_range(0, 1) != 0);
        id64  = {32'($urandom), 32'($urandom)};
      end else begin
        flush = 1'b0; iv8 = 1'b0; iv64 = 1'b0; or8 = 1'b1; or64 = 1'b1;
      end
      stall8  = (sz8 != 0) && !or8 && !flush;
      stall64 = (sz64 != 0) && !or64 && !flush;
      last8   = od8;
      last64  = od64;
      if (flush) begin
        q8.delete();
        q64.delete();
      end else begin
        if (sz8 != 0 && or8) drop8 = q8.pop_front();
        if (iv8 && sz8 != 2) q8.push_back(id8);
        if (sz64 != 0 && or64) drop64 = q64.pop_front();
        if (iv64 && sz64 != 2) q64.push_back(id64);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: time=%0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill_drain();
    test_flush_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
